// File: rtl/uart_ctrl_if.sv
// Processor peripheral bus between the CPU side and uart_ctrl.
// One access per sel, completed by a single-cycle ready pulse.
interface uart_ctrl_if;
   logic        sel;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport master (output sel, we, addr, wdata, input rdata, ready);
   modport slave  (input sel, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/uart_ctrl.sv
// UART sequencing controller: TX/RX byte FIFOs, bus register file and TX launch FSM.
// Registers: 0 DATA, 1 STATUS (W1C overflow bits), 2 CTRL, 3 reserved.
module uart_ctrl #(
   parameter int FIFO_AW = 4
) (
   input  logic       clk,
   input  logic       reset,
   uart_ctrl_if.slave bus,
   output logic       irq,
   output logic [7:0] u_tx_data,
   output logic       u_tx_start,
   input  logic       u_tx_busy,
   input  logic [7:0] u_rx_data,
   input  logic       u_rx_ready
);
   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} tx_state_t;

   tx_state_t        state, state_next;
   logic [1:0]       launch_cnt;
   logic [7:0]       tx_mem [DEPTH];
   logic [7:0]       rx_mem [DEPTH];
   logic [FIFO_AW:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr, tx_count, rx_count;
   logic             tx_full, tx_empty, rx_full, rx_empty, tx_active;
   logic             tx_ovf, rx_ovf;
   logic [2:0]       ctrl;
   logic             accept, wr_data, rd_data, wr_status, wr_ctrl, flush;
   logic             tx_push, tx_drop, tx_pop, rx_push, rx_drop, rx_pop;
   logic [1:0]       reg_sel;
   logic [31:0]      status, rd_mux;
   logic             unused_bits;

   assign tx_full  = (tx_wptr[FIFO_AW] != tx_rptr[FIFO_AW]) &&
                     (tx_wptr[FIFO_AW-1:0] == tx_rptr[FIFO_AW-1:0]);
   assign rx_full  = (rx_wptr[FIFO_AW] != rx_rptr[FIFO_AW]) &&
                     (rx_wptr[FIFO_AW-1:0] == rx_rptr[FIFO_AW-1:0]);
   assign tx_empty = (tx_wptr == tx_rptr);
   assign rx_empty = (rx_wptr == rx_rptr);
   assign tx_count = tx_wptr - tx_rptr;
   assign rx_count = rx_wptr - rx_rptr;
   assign tx_active = (state != IDLE);

   assign reg_sel   = bus.addr[3:2];
   assign accept    = bus.sel && !bus.ready;
   assign wr_data   = accept &&  bus.we && (reg_sel == 2'd0);
   assign rd_data   = accept && !bus.we && (reg_sel == 2'd0);
   assign wr_status = accept &&  bus.we && (reg_sel == 2'd1);
   assign wr_ctrl   = accept &&  bus.we && (reg_sel == 2'd2);
   assign flush     = wr_ctrl && bus.wdata[3];

   // A pop in the same cycle frees the slot, so a push into a full FIFO is not an overflow.
   assign rx_pop  = rd_data && !rx_empty;
   assign rx_push = u_rx_ready && !flush && (!rx_full || rx_pop);
   assign rx_drop = u_rx_ready && !flush && rx_full && !rx_pop;
   assign tx_push = wr_data && (!tx_full || tx_pop);
   assign tx_drop = wr_data && tx_full && !tx_pop;

   assign unused_bits = ^{bus.wdata[31:8], bus.addr[1:0]};

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr[FIFO_AW-1:0]] <= bus.wdata[7:0];
      if (rx_push) rx_mem[rx_wptr[FIFO_AW-1:0]] <= u_rx_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_wptr <= '0;
         tx_rptr <= '0;
         rx_wptr <= '0;
         rx_rptr <= '0;
         tx_ovf  <= 1'b0;
         rx_ovf  <= 1'b0;
         ctrl    <= '0;
      end else begin
         if (tx_push) tx_wptr <= tx_wptr + 1'b1;
         if (rx_push) rx_wptr <= rx_wptr + 1'b1;
         if (flush) begin
            tx_rptr <= tx_wptr;
            rx_rptr <= rx_wptr;
         end else begin
            if (tx_pop) tx_rptr <= tx_rptr + 1'b1;
            if (rx_pop) rx_rptr <= rx_rptr + 1'b1;
         end
         if (tx_drop) tx_ovf <= 1'b1;
         else if (wr_status && bus.wdata[5]) tx_ovf <= 1'b0;
         if (rx_drop) rx_ovf <= 1'b1;
         else if (wr_status && bus.wdata[6]) rx_ovf <= 1'b0;
         if (wr_ctrl) ctrl <= bus.wdata[2:0];
      end
   end

   always_comb begin
      status = '0;
      status[0] = tx_full;
      status[1] = tx_empty;
      status[2] = rx_full;
      status[3] = rx_empty;
      status[4] = tx_active;
      status[5] = tx_ovf;
      status[6] = rx_ovf;
      status[8 +: FIFO_AW+1]  = rx_count;
      status[16 +: FIFO_AW+1] = tx_count;
   end

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         2'd0:    rd_mux[7:0] = rx_empty ? 8'h00 : rx_mem[rx_rptr[FIFO_AW-1:0]];
         2'd1:    rd_mux = status;
         2'd2:    rd_mux[2:0] = ctrl;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.ready <= 1'b0;
         bus.rdata <= '0;
         irq       <= 1'b0;
      end else begin
         bus.ready <= accept;
         bus.rdata <= (accept && !bus.we) ? rd_mux : '0;
         irq       <= (ctrl[0] && !rx_empty) ||
                      (ctrl[1] && tx_empty && !tx_active) ||
                      (ctrl[2] && (tx_ovf || rx_ovf));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         launch_cnt <= '0;
         u_tx_start <= 1'b0;
         u_tx_data  <= '0;
      end else begin
         state      <= state_next;
         launch_cnt <= (state == LAUNCH) ? launch_cnt + 1'b1 : '0;
         u_tx_start <= tx_pop;
         if (tx_pop) u_tx_data <= tx_mem[tx_rptr[FIFO_AW-1:0]];
      end
   end

   // LAUNCH gives the core four cycles to raise busy before the byte is assumed sent.
   always_comb begin
      state_next = state;
      tx_pop     = 1'b0;
      case (state)
         IDLE: begin
            if (!tx_empty && !u_tx_busy) begin
               tx_pop     = 1'b1;
               state_next = LAUNCH;
            end
         end
         LAUNCH: begin
            if (u_tx_busy)               state_next = WAIT_DONE;
            else if (launch_cnt == 2'd3) state_next = IDLE;
         end
         WAIT_DONE: begin
            if (!u_tx_busy) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: queue-based register/FIFO model plus a simple UART core model.
// One negedge compare process checks every bus response and every TX launch.
module tb_uart_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       irq;
   logic [7:0] u_tx_data;
   logic       u_tx_start;
   logic       u_tx_busy;
   logic [7:0] u_rx_data = 8'h00;
   logic       u_rx_ready = 1'b0;

   uart_ctrl_if bus ();

   uart_ctrl #(.FIFO_AW(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .irq        (irq),
      .u_tx_data  (u_tx_data),
      .u_tx_start (u_tx_start),
      .u_tx_busy  (u_tx_busy),
      .u_rx_data  (u_rx_data),
      .u_rx_ready (u_rx_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [7:0]  m_tx[$], m_rx[$], launched[$];
   logic        m_tx_ovf = 1'b0, m_rx_ovf = 1'b0;
   logic [2:0]  m_ctrl = '0;
   logic [31:0] exp_v[$], exp_m[$];
   bit          exp_c[$];
   string       exp_n[$];

   // Core: busy rises the cycle after a start pulse and stays high core_len cycles.
   int core_len = 10;
   int busy_cnt;
   always @(posedge clk or posedge reset) begin
      if (reset) busy_cnt <= 0;
      else if (u_tx_start && busy_cnt == 0) busy_cnt <= core_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign u_tx_busy = (busy_cnt != 0);

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, got, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout/absent expected=event", nm);
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = '0;
      s[0] = (m_tx.size() == 16);
      s[1] = (m_tx.size() == 0);
      s[2] = (m_rx.size() == 16);
      s[3] = (m_rx.size() == 0);
      s[5] = m_tx_ovf;
      s[6] = m_rx_ovf;
      s[12:8]  = 5'(m_rx.size());
      s[20:16] = 5'(m_tx.size());
      return s;
   endfunction

   task automatic rx_model_push(input logic [7:0] b);
      if (m_rx.size() < 16) m_rx.push_back(b);
      else m_rx_ovf = 1'b1;
   endtask

   logic [31:0] cv, cm;
   bit          cc;
   string       cn;
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.ready) begin
            if (exp_v.size() == 0) fail_now("spurious_ready");
            else begin
               cv = exp_v.pop_front();
               cm = exp_m.pop_front();
               cc = exp_c.pop_front();
               cn = exp_n.pop_front();
               if (cc) chk(cn, bus.rdata & cm, cv & cm);
            end
         end
         if (u_tx_start) begin
            chk("start_while_busy", {31'b0, u_tx_busy}, 32'h0);
            launched.push_back(u_tx_data);
            if (m_tx.size() == 0) fail_now("unexpected_start");
            else chk("tx_data", {24'b0, u_tx_data}, {24'b0, m_tx.pop_front()});
         end
      end
   end

   task automatic bus_access(input logic w, input logic [3:0] a, input logic [31:0] wd,
                             input logic [31:0] mask, input string nm, input bit inj,
                             input logic [7:0] ib, output logic [31:0] rd);
      logic [31:0] e;
      bit ok;
      e = '0;
      ok = 1'b0;
      @(negedge clk);
      bus.sel = 1'b1; bus.we = w; bus.addr = a; bus.wdata = wd;
      if (w) begin
         case (a[3:2])
            2'd0: if (m_tx.size() < 16) m_tx.push_back(wd[7:0]); else m_tx_ovf = 1'b1;
            2'd1: begin
               if (wd[5]) m_tx_ovf = 1'b0;
               if (wd[6]) m_rx_ovf = 1'b0;
            end
            2'd2: begin
               m_ctrl = wd[2:0];
               if (wd[3]) begin m_tx.delete(); m_rx.delete(); end
            end
            default: ;
         endcase
      end else begin
         case (a[3:2])
            2'd0:    e = (m_rx.size() != 0) ? {24'b0, m_rx.pop_front()} : 32'h0;
            2'd1:    e = model_status();
            2'd2:    e = {29'b0, m_ctrl};
            default: e = 32'h0;
         endcase
      end
      if (inj) begin
         u_rx_ready = 1'b1;
         u_rx_data  = ib;
         rx_model_push(ib);
      end
      exp_v.push_back(e); exp_m.push_back(mask); exp_c.push_back(!w); exp_n.push_back(nm);
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         if (bus.ready) ok = 1'b1;
         u_rx_ready = 1'b0;
      end
      bus.sel = 1'b0;
      if (!ok) fail_now({nm, "_ready"});
      rd = bus.rdata;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      logic [31:0] unused_rd;
      bus_access(1'b1, a, d, '1, "write", 1'b0, 8'h00, unused_rd);
   endtask

   task automatic rd_reg(input logic [3:0] a, input string nm, output logic [31:0] rd);
      bus_access(1'b0, a, 32'h0, '1, nm, 1'b0, 8'h00, rd);
   endtask

   task automatic rx_inject(input logic [7:0] b);
      @(negedge clk);
      u_rx_ready = 1'b1;
      u_rx_data  = b;
      rx_model_push(b);
      @(negedge clk);
      u_rx_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rdata"}, bus.rdata, 32'h0);
      chk({tag, "_ready"}, {31'b0, bus.ready}, 32'h0);
      chk({tag, "_irq"}, {31'b0, irq}, 32'h0);
      chk({tag, "_tx_data"}, {24'b0, u_tx_data}, 32'h0);
      chk({tag, "_tx_start"}, {31'b0, u_tx_start}, 32'h0);
   endtask

   logic [31:0] r;
   int n0;
   initial begin
      bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      reset = 1'b0;

      rd_reg(4'h4, "status_reset", r);
      chk("status_reset_lit", r, 32'h0000_000A);

      // Three bytes through the core handshake.
      wr(4'h0, 32'h41); wr(4'h0, 32'h42); wr(4'h0, 32'h43);
      for (int i = 0; i < 300 && !(launched.size() == 3 && !u_tx_busy); i++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk("launch_count", launched.size(), 3);
      if (launched.size() == 3) begin
         chk("launch0", {24'b0, launched[0]}, 32'h41);
         chk("launch1", {24'b0, launched[1]}, 32'h42);
         chk("launch2", {24'b0, launched[2]}, 32'h43);
      end
      rd_reg(4'h4, "status_tx_done", r);
      chk("status_tx_done_lit", r, 32'h0000_000A);

      // RX buffering and drain, including empty read.
      rx_inject(8'h10); rx_inject(8'h20); rx_inject(8'h30);
      rd_reg(4'h4, "status_rx3", r);
      chk("status_rx3_lit", r, 32'h0000_0302);
      rd_reg(4'h0, "rx_rd0", r); chk("rx_rd0_lit", r, 32'h10);
      rd_reg(4'h0, "rx_rd1", r); chk("rx_rd1_lit", r, 32'h20);
      rd_reg(4'h0, "rx_rd2", r); chk("rx_rd2_lit", r, 32'h30);
      rd_reg(4'h0, "rx_rd3", r); chk("rx_rd_empty_lit", r, 32'h0);
      rd_reg(4'h4, "status_rx0", r);
      chk("status_rx0_lit", r, 32'h0000_000A);

      // Overflow: 17th byte dropped, then W1C.
      for (int i = 0; i < 17; i++) rx_inject(8'(8'h80 + i));
      rd_reg(4'h4, "status_rx_ovf", r);
      chk("status_rx_ovf_lit", r, 32'h0000_1046);
      wr(4'h4, 32'h40);
      rd_reg(4'h4, "status_ovf_clr", r);
      chk("status_ovf_clr_lit", r, 32'h0000_1006);

      // Pop and push on a full RX FIFO in one cycle.
      bus_access(1'b0, 4'h0, 32'h0, '1, "rx_simul", 1'b1, 8'h99, r);
      chk("rx_simul_lit", r, 32'h80);
      rd_reg(4'h4, "status_simul", r);
      chk("status_simul_lit", r, 32'h0000_1006);
      for (int i = 0; i < 16; i++) rd_reg(4'h0, "rx_drain", r);
      chk("rx_drain_last_lit", r, 32'h99);
      rd_reg(4'h4, "status_drained", r);
      chk("status_drained_lit", r, 32'h0000_000A);

      // Interrupt timing.
      wr(4'h8, 32'h1);
      chk("irq_rxie_empty", {31'b0, irq}, 32'h0);
      rx_inject(8'h5A);
      chk("irq_push_edge", {31'b0, irq}, 32'h0);
      @(negedge clk);
      chk("irq_rx_rise", {31'b0, irq}, 32'h1);
      rd_reg(4'h0, "irq_rx_read", r);
      chk("irq_pop_edge", {31'b0, irq}, 32'h1);
      @(negedge clk);
      chk("irq_rx_fall", {31'b0, irq}, 32'h0);
      wr(4'h8, 32'h2);
      chk("irq_txie_edge", {31'b0, irq}, 32'h0);
      @(negedge clk);
      chk("irq_tx_idle", {31'b0, irq}, 32'h1);

      // Flush and self-clearing CTRL bit.
      rx_inject(8'h11); rx_inject(8'h22);
      wr(4'h8, 32'h0A);
      rd_reg(4'h8, "ctrl_after_flush", r);
      chk("ctrl_after_flush_lit", r, 32'h2);
      rd_reg(4'h4, "status_flush", r);
      chk("status_flush_lit", r, 32'h0000_000A);

      // Reset while a long transfer is in WAIT_DONE with five bytes queued.
      core_len = 40;
      for (int i = 0; i < 6; i++) wr(4'h0, 32'(8'h50 + i));
      bus_access(1'b0, 4'h4, 32'h0, ~32'h10, "status_midtx", 1'b0, 8'h00, r);
      chk("midtx_count_lit", {27'b0, r[20:16]}, 32'd5);
      chk("midtx_active_lit", {31'b0, r[4]}, 32'h1);
      @(negedge clk);
      reset = 1'b1;
      m_tx.delete(); m_rx.delete();
      m_tx_ovf = 1'b0; m_rx_ovf = 1'b0; m_ctrl = '0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      n0 = launched.size();
      rd_reg(4'h4, "status_post_rst", r);
      chk("status_post_rst_lit", r, 32'h0000_000A);
      repeat (30) @(negedge clk);
      chk("no_start_after_rst", launched.size(), n0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
